// File: rtl/peripheral_wb_burst_master_if.sv
// Wishbone B3 bus bundle between the burst master and a slave or interconnect.
// Member names keep the master's point of view (_o driven by master, _i by slave).
interface peripheral_wb_burst_master_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
);
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_we_o;
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW/8-1:0] wb_sel_o;
    logic [2:0]      wb_cti_o;
    logic [1:0]      wb_bte_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_ack_i;
    logic            wb_err_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

// File: rtl/peripheral_wb_burst_master.sv
// Wishbone B3 burst master: turns one command into a complete classic or
// incrementing/wrapping burst cycle, reporting read beats and completion.
module peripheral_wb_burst_master #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic          req_burst_i,
    input  logic [AW-1:0] req_adr_i,
    input  logic [4:0]    req_len_i,
    input  logic [1:0]    req_bte_i,
    input  logic [DW-1:0] wdat_i,
    output logic          wdat_ack_o,
    output logic [DW-1:0] rdat_o,
    output logic          rdat_valid_o,
    output logic          done_o,
    output logic          err_o,
    peripheral_wb_burst_master_if.master wb
);
    localparam int unsigned Shift = $clog2(DW / 8);

    typedef enum logic {StIdle, StActive} state_e;

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic          burst_q, burst_d;
    logic          single_q, single_d;
    logic [1:0]    bte_q, bte_d;
    logic [4:0]    rem_q, rem_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [DW-1:0] rdat_q, rdat_d;
    logic          rdat_valid_q, rdat_valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          active, beat;
    logic [4:0]    len_norm;
    logic [AW-1:0] word_a, word_inc, word_n, wrap_mask, adr_next;

    assign active = (state_q == StActive);
    assign beat   = active & wb.wb_ack_i & ~wb.wb_err_i;

    always_comb begin
        if (req_len_i == 5'd0) begin
            len_norm = 5'd1;
        end else if (req_len_i > 5'd16) begin
            len_norm = 5'd16;
        end else begin
            len_norm = req_len_i;
        end
    end

    // Address stepping works on beat (word) indices; wrapping only touches the low bits.
    always_comb begin
        word_a   = adr_q >> Shift;
        word_inc = word_a + AW'(1);
        unique case (bte_q)
            2'd1:    wrap_mask = AW'(3);
            2'd2:    wrap_mask = AW'(7);
            2'd3:    wrap_mask = AW'(15);
            default: wrap_mask = '0;
        endcase
        if (burst_q && (bte_q != 2'd0)) begin
            word_n = (word_a & ~wrap_mask) | (word_inc & wrap_mask);
        end else begin
            word_n = word_inc;
        end
        adr_next = word_n << Shift;
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        burst_d      = burst_q;
        single_d     = single_q;
        bte_d        = bte_q;
        rem_d        = rem_q;
        adr_d        = adr_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    we_d     = req_we_i;
                    burst_d  = req_burst_i;
                    single_d = (len_norm == 5'd1);
                    bte_d    = req_bte_i;
                    rem_d    = len_norm;
                    adr_d    = req_adr_i;
                    state_d  = StActive;
                end
            end
            StActive: begin
                // Error terminates the command and takes precedence over a coincident ack.
                if (wb.wb_err_i) begin
                    rem_d   = 5'd0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (wb.wb_ack_i) begin
                    rem_d = rem_q - 5'd1;
                    adr_d = adr_next;
                    if (!we_q) begin
                        rdat_d       = wb.wb_dat_i;
                        rdat_valid_d = 1'b1;
                    end
                    if (rem_q == 5'd1) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            burst_q      <= 1'b0;
            single_q     <= 1'b0;
            bte_q        <= 2'd0;
            rem_q        <= 5'd0;
            adr_q        <= '0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            burst_q      <= burst_d;
            single_q     <= single_d;
            bte_q        <= bte_d;
            rem_q        <= rem_d;
            adr_q        <= adr_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        req_ready_o  = ~active;
        wdat_ack_o   = beat & we_q;
        rdat_o       = rdat_q;
        rdat_valid_o = rdat_valid_q;
        done_o       = done_q;
        err_o        = err_q;
        wb.wb_cyc_o  = active;
        wb.wb_stb_o  = active;
        wb.wb_we_o   = active & we_q;
        wb.wb_adr_o  = adr_q;
        wb.wb_dat_o  = (active && we_q) ? wdat_i : '0;
        wb.wb_sel_o  = {(DW / 8){active}};
        wb.wb_bte_o  = (active && burst_q) ? bte_q : 2'd0;
        wb.wb_cti_o  = 3'b000;
        if (active && burst_q && !single_q) begin
            wb.wb_cti_o = (rem_q == 5'd1) ? 3'b111 : 3'b010;
        end
    end
endmodule

// File: tb/tb_peripheral_wb_burst_master.sv
// Randomized and directed bench for peripheral_wb_burst_master, checked every
// cycle against a beat-list model built from the command.
module tb_peripheral_wb_burst_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid_i = 1'b0, req_we_i = 1'b0, req_burst_i = 1'b0;
    logic [31:0] req_adr_i = '0;
    logic [4:0]  req_len_i = '0;
    logic [1:0]  req_bte_i = '0;
    logic [31:0] wdat_i = '0;
    logic        req_ready_o, wdat_ack_o, rdat_valid_o, done_o, err_o;
    logic [31:0] rdat_o;

    peripheral_wb_burst_master_if #(.DW(32), .AW(32)) wb_bus ();

    peripheral_wb_burst_master #(.DW(32), .AW(32)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_burst_i(req_burst_i), .req_adr_i(req_adr_i),
        .req_len_i(req_len_i), .req_bte_i(req_bte_i), .wdat_i(wdat_i), .wdat_ack_o(wdat_ack_o),
        .rdat_o(rdat_o), .rdat_valid_o(rdat_valid_o), .done_o(done_o), .err_o(err_o),
        .wb(wb_bus)
    );

    // Second instance at DW=64 for the wrap-8 case.
    logic        r64_valid = 1'b0, r64_ready, r64_wack, r64_rv, r64_done, r64_err;
    logic [63:0] r64_rdat;
    logic [63:0] r64_wdat = '0;
    peripheral_wb_burst_master_if #(.DW(64), .AW(32)) wb64 ();

    peripheral_wb_burst_master #(.DW(64), .AW(32)) dut64 (
        .clk(clk), .rst(rst), .req_valid_i(r64_valid), .req_ready_o(r64_ready),
        .req_we_i(1'b0), .req_burst_i(1'b1), .req_adr_i(32'h38), .req_len_i(5'd8),
        .req_bte_i(2'd2), .wdat_i(r64_wdat), .wdat_ack_o(r64_wack), .rdat_o(r64_rdat),
        .rdat_valid_o(r64_rv), .done_o(r64_done), .err_o(r64_err), .wb(wb64)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected byte address of beat i, computed directly from the burst rules.
    function automatic logic [31:0] exp_adr(input logic [31:0] base, input int i,
                                            input bit burst, input logic [1:0] bte);
        logic [31:0] blk;
        if (burst && bte != 2'd0) begin
            blk = 32'd8 << bte;
            return (base & ~(blk - 1)) | ((base + 32'(4 * i)) & (blk - 1));
        end
        return base + 32'(4 * i);
    endfunction

    function automatic logic [2:0] exp_cti(input int n, input int i, input bit burst);
        if (!burst || n == 1) return 3'b000;
        return (i == n - 1) ? 3'b111 : 3'b010;
    endfunction

    // Model state
    bit          m_act = 0, m_we = 0, m_burst = 0, m_done = 0, m_err = 0, m_rv = 0;
    int          m_n = 0, m_idx = 0;
    logic [1:0]  m_bte = '0;
    logic [31:0] m_base = '0, m_rd = '0;
    bit          wack_prev = 0;

    always @(negedge clk) begin
        wack_prev = 0;
        if (rst) begin
            chk("rst_cyc", wb_bus.wb_cyc_o, 0);
            chk("rst_stb", wb_bus.wb_stb_o, 0);
            chk("rst_we", wb_bus.wb_we_o, 0);
            chk("rst_adr", wb_bus.wb_adr_o, 0);
            chk("rst_cti", wb_bus.wb_cti_o, 0);
            chk("rst_bte", wb_bus.wb_bte_o, 0);
            chk("rst_sel", wb_bus.wb_sel_o, 0);
            chk("rst_dat", wb_bus.wb_dat_o, 0);
            chk("rst_ready", req_ready_o, 1);
            chk("rst_done", done_o, 0);
            chk("rst_err", err_o, 0);
            chk("rst_rv", rdat_valid_o, 0);
            chk("rst_rdat", rdat_o, 0);
            chk("rst_wack", wdat_ack_o, 0);
            m_act = 0; m_done = 0; m_err = 0; m_rv = 0;
        end else begin
            chk("cyc", wb_bus.wb_cyc_o, m_act);
            chk("stb", wb_bus.wb_stb_o, m_act);
            chk("ready", req_ready_o, !m_act);
            chk("done", done_o, m_done);
            chk("err", err_o, m_done && m_err);
            chk("rdat_valid", rdat_valid_o, m_rv);
            if (m_rv) chk("rdat", rdat_o, m_rd);
            if (m_act) begin
                chk("adr", wb_bus.wb_adr_o, exp_adr(m_base, m_idx, m_burst, m_bte));
                chk("cti", wb_bus.wb_cti_o, exp_cti(m_n, m_idx, m_burst));
                chk("bte", wb_bus.wb_bte_o, m_burst ? m_bte : 2'd0);
                chk("we", wb_bus.wb_we_o, m_we);
                chk("sel", wb_bus.wb_sel_o, 4'hf);
                chk("dat_o", wb_bus.wb_dat_o, m_we ? wdat_i : 32'd0);
                chk("wdat_ack", wdat_ack_o, m_we && wb_bus.wb_ack_i && !wb_bus.wb_err_i);
            end else begin
                chk("idle_cti", wb_bus.wb_cti_o, 0);
                chk("idle_bte", wb_bus.wb_bte_o, 0);
                chk("idle_sel", wb_bus.wb_sel_o, 0);
                chk("idle_dat", wb_bus.wb_dat_o, 0);
                chk("idle_wack", wdat_ack_o, 0);
            end
            wack_prev = wdat_ack_o;
            m_done = 0;
            m_rv   = 0;
            if (m_act) begin
                if (wb_bus.wb_err_i) begin
                    m_act = 0; m_done = 1; m_err = 1;
                end else if (wb_bus.wb_ack_i) begin
                    if (!m_we) begin
                        m_rv = 1;
                        m_rd = wb_bus.wb_dat_i;
                    end
                    m_idx++;
                    if (m_idx == m_n) begin
                        m_act = 0; m_done = 1; m_err = 0;
                    end
                end
            end else if (req_valid_i) begin
                m_act   = 1;
                m_idx   = 0;
                m_we    = req_we_i;
                m_burst = req_burst_i;
                m_bte   = req_bte_i;
                m_base  = req_adr_i;
                m_n     = (req_len_i == 0) ? 1 : (req_len_i > 16) ? 16 : int'(req_len_i);
            end
        end
    end

    // Slave: scripted {err,ack} pairs first, otherwise random responses.
    int          ack_pct = 100;
    int          err_pct = 0;
    bit          rd_fixed_en = 0;
    logic [31:0] rd_fixed = '0;
    logic [1:0]  pat_q[$];

    always @(posedge clk) begin
        logic [1:0] p;
        #1;
        if (wack_prev) wdat_i = $urandom;
        wb_bus.wb_dat_i = rd_fixed_en ? rd_fixed : $urandom;
        if (wb_bus.wb_cyc_o) begin
            if (pat_q.size() > 0) begin
                p = pat_q.pop_front();
            end else begin
                p[0] = ($urandom_range(99) < ack_pct);
                p[1] = ($urandom_range(99) < err_pct);
            end
            wb_bus.wb_ack_i = p[0];
            wb_bus.wb_err_i = p[1];
        end else begin
            wb_bus.wb_ack_i = 1'b0;
            wb_bus.wb_err_i = 1'b0;
        end
        wb64.wb_ack_i = wb64.wb_cyc_o;
        wb64.wb_err_i = 1'b0;
        wb64.wb_dat_i = {$urandom, $urandom};
    end

    task automatic send(input bit we, input bit burst, input logic [31:0] adr,
                        input logic [4:0] len, input logic [1:0] bte);
        bit acc = 0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b1; req_we_i = we; req_burst_i = burst;
        req_adr_i = adr; req_len_i = len; req_bte_i = bte;
        for (int k = 0; k < 500 && !acc; k++) begin
            @(negedge clk);
            if (req_ready_o) acc = 1;
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    logic [31:0] w_adr[0:39];
    logic [2:0]  w_cti[0:39];
    logic [1:0]  w_bte[0:39];
    logic        w_cyc[0:39];
    int          w_wack, w_rv, w_done;
    logic        w_err, w_rdy;
    logic [31:0] w_rd;

    // Records per-cycle bus state; cycle 1 is the first cycle after acceptance.
    task automatic watch(input int maxc);
        w_wack = 0; w_rv = 0; w_done = 0;
        for (int c = 1; c <= maxc && w_done == 0; c++) begin
            @(negedge clk);
            w_adr[c] = wb_bus.wb_adr_o;
            w_cti[c] = wb_bus.wb_cti_o;
            w_bte[c] = wb_bus.wb_bte_o;
            w_cyc[c] = wb_bus.wb_cyc_o;
            if (wdat_ack_o) w_wack++;
            if (rdat_valid_o) begin
                w_rv++;
                w_rd = rdat_o;
            end
            if (done_o) begin
                w_done = c; w_err = err_o; w_rdy = req_ready_o;
            end
        end
        if (w_done == 0) chk("done_timeout", 0, 1);
    endtask

    logic [31:0] e_lin[4]  = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    logic [31:0] e_wrap[4] = '{32'h1008, 32'h100C, 32'h1000, 32'h1004};
    logic [31:0] e64[8]    = '{32'h38, 32'h00, 32'h08, 32'h10, 32'h18, 32'h20, 32'h28, 32'h30};
    logic [2:0]  e_cti4[4] = '{3'b010, 3'b010, 3'b010, 3'b111};

    initial begin
        wdat_i = $urandom;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Classic single read
        rd_fixed_en = 1; rd_fixed = 32'hDEADBEEF;
        send(0, 0, 32'h100, 5'd1, 2'd0);
        watch(10);
        rd_fixed_en = 0;
        chk("t1_adr", w_adr[1], 32'h100);
        chk("t1_cti", w_cti[1], 3'b000);
        chk("t1_done_cycle", w_done, 2);
        chk("t1_rv_count", w_rv, 1);
        chk("t1_rdat", w_rd, 32'hDEADBEEF);
        chk("t1_err", w_err, 0);

        // Linear write burst
        send(1, 1, 32'h1000, 5'd4, 2'd0);
        watch(20);
        for (int i = 0; i < 4; i++) begin
            chk("t2_adr", w_adr[i + 1], e_lin[i]);
            chk("t2_cti", w_cti[i + 1], e_cti4[i]);
        end
        chk("t2_wack_count", w_wack, 4);
        chk("t2_done_cycle", w_done, 5);

        // Wrap-4 read burst
        send(0, 1, 32'h1008, 5'd4, 2'd1);
        watch(20);
        for (int i = 0; i < 4; i++) chk("t3_adr", w_adr[i + 1], e_wrap[i]);
        chk("t3_bte", w_bte[1], 2'b01);
        chk("t3_done_cycle", w_done, 5);

        // Linear write with two wait states on beat 2
        pat_q = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
        send(1, 1, 32'h2000, 5'd3, 2'd0);
        watch(20);
        chk("t4_adr1", w_adr[1], 32'h2000);
        for (int c = 2; c <= 4; c++) begin
            chk("t4_adr_hold", w_adr[c], 32'h2004);
            chk("t4_cti_hold", w_cti[c], 3'b010);
        end
        chk("t4_adr3", w_adr[5], 32'h2008);
        chk("t4_cti3", w_cti[5], 3'b111);
        chk("t4_wack_count", w_wack, 3);
        chk("t4_done_cycle", w_done, 6);

        // Read with ack+err on beat 2
        pat_q = '{2'b01, 2'b11};
        send(0, 1, 32'h3000, 5'd4, 2'd0);
        watch(20);
        chk("t5_rv_count", w_rv, 1);
        chk("t5_cyc_err_cycle", w_cyc[2], 1);
        chk("t5_cyc_after", w_cyc[3], 0);
        chk("t5_done_cycle", w_done, 3);
        chk("t5_err", w_err, 1);
        chk("t5_ready", w_rdy, 1);

        // Reset pulse mid-burst
        send(0, 1, 32'h3000, 5'd8, 2'd0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("t6_cyc_async", wb_bus.wb_cyc_o, 0);
        chk("t6_stb_async", wb_bus.wb_stb_o, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t6_no_done_rst", done_o, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_no_done", done_o, 0);
            chk("t6_cyc_low", wb_bus.wb_cyc_o, 0);
        end

        // DW=64 wrap-8 read on the second instance
        @(posedge clk);
        #1;
        chk("t7_ready", r64_ready, 1);
        r64_valid = 1'b1;
        @(posedge clk);
        #1 r64_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t7_adr", wb64.wb_adr_o, e64[i]);
            chk("t7_bte", wb64.wb_bte_o, 2'd2);
            if (i == 7) chk("t7_cti_last", wb64.wb_cti_o, 3'b111);
        end
        @(negedge clk);
        chk("t7_done", r64_done, 1);

        // Random commands against the per-cycle model
        for (int n = 0; n < 300; n++) begin
            ack_pct = $urandom_range(100, 40);
            err_pct = ($urandom_range(3) == 0) ? $urandom_range(8) : 0;
            repeat ($urandom_range(2)) @(posedge clk);
            send($urandom_range(1), $urandom_range(1), $urandom & 32'hFFFF_FFFC,
                 5'($urandom_range(31)), 2'($urandom_range(3)));
        end
        ack_pct = 100;
        err_pct = 0;
        repeat (40) @(posedge clk);
        chk("final_idle", req_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/peripheral_wb_burst_master.md
# peripheral_wb_burst_master

Wishbone B3 burst master that turns a single command (start address, beat count, burst type, wrap mode) into a complete bus cycle. It drives CYC/STB/CTI/BTE and steps the address per the B3 incrementing/wrapping rules using the shared Wishbone constants and next-address arithmetic. It sits directly upstream of any B3 slave, between a DMA/bridge front end and the Wishbone interconnect.

## Interface
- DW, 32, data width; legal values 32 or 64; byte shift = log2(DW/8)
- AW, 32, address width (byte address)
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when high together with req_valid_i
- req_we_i  in  1  1 = write, 0 = read
- req_burst_i  in  1  1 = incrementing burst, 0 = back-to-back classic cycles
- req_adr_i  in  AW  start byte address, DW-aligned
- req_len_i  in  5  beat count 1..16; 0 treated as 1; >16 saturates to 16
- req_bte_i  in  2  0 linear, 1 wrap-4, 2 wrap-8, 3 wrap-16
- wdat_i  in  DW  current write beat, held until wdat_ack_o
- wdat_ack_o  out  1  write beat consumed this cycle
- rdat_o  out  DW  read beat
- rdat_valid_o  out  1  rdat_o valid, one cycle per beat
- done_o  out  1  one-cycle pulse at command end
- err_o  out  1  with done_o: command ended by wb_err_i
- wb_cyc_o, wb_stb_o, wb_we_o  out  1  B3 master controls
- wb_adr_o  out  AW  byte address
- wb_dat_o  out  DW  equals wdat_i while writing, else 0
- wb_sel_o  out  DW/8  all ones during cycle, else 0
- wb_cti_o  out  3  cycle type identifier
- wb_bte_o  out  2  burst type extension
- wb_dat_i  in  DW  read data
- wb_ack_i, wb_err_i  in  1  slave termination

## Operation
- States IDLE, ACTIVE. Reset: IDLE; req_ready_o=1; all other outputs 0 (wb_adr_o, wb_cti_o, wb_bte_o, rdat_o included).
- IDLE: req_ready_o=1. On req_valid_i: latch command, remaining=len, go ACTIVE.
- ACTIVE: req_ready_o=0; wb_cyc_o=wb_stb_o=1 continuously; wb_we_o=latched we; wb_bte_o=latched bte in burst mode, 0 in classic.
- CTI: classic mode, or len=1 -> 3'b000 every beat. Burst with len>1 -> 3'b010 while remaining>1, 3'b111 on last beat.
- Beat accepted when wb_ack_i & ~wb_err_i while ACTIVE: remaining-1; wb_adr_o <= next address.
- Next address: a=adr>>shift; burst: linear a+1, wrap-N increments low log2(N) bits mod N, upper bits unchanged; classic: always linear a+1 (bte ignored); result <<shift.
- Read beat: rdat_o<=wb_dat_i, rdat_valid_o<=1 next cycle. Write beat: wdat_ack_o=wb_ack_i & ~wb_err_i & ACTIVE & we (combinational).
- Last beat accepted: cyc/stb/sel/cti/bte cleared next cycle, done_o=1, state IDLE, req_ready_o=1 same cycle.
- wb_err_i while ACTIVE: beat not counted, no rdat_valid/wdat_ack; next cycle cycle ends, done_o=err_o=1.
- Simultaneous ack and err: err wins.
- Reset mid-burst: cyc/stb drop asynchronously; no done_o; remaining cleared.

## Timing
- Command accepted at cycle T -> cyc/stb/adr/cti valid at T+1.
- Zero wait states: one beat per cycle; N beats finish with done_o at T+N+1.
- Wait states (ack=0): adr, cti, we, dat_o held unchanged.
- rdat_valid_o lags the read ack by 1 cycle; final rdat_valid_o coincides with done_o.
- New command earliest at done_o cycle; its cyc/stb rise the following cycle (cyc low ≥1 cycle between commands).
- wdat_ack_o is same-cycle with ack; source must present the next beat the following cycle.

## Test plan
- Classic read len=1 @0x100, ack at T+1 with 0xDEADBEEF -> cti=000, adr=0x100; rdat_o=0xDEADBEEF with rdat_valid_o and done_o at T+2; err_o=0.
- Linear burst write len=4 @0x1000, DW=32 -> adr 0x1000/0x1004/0x1008/0x100C, cti 010/010/010/111, four wdat_ack_o pulses, done_o at T+5.
- Wrap-4 read len=4 @0x1008 -> adr 0x1008, 0x100C, 0x1000, 0x1004; bte=01.
- DW=64 wrap-8 read len=8 @0x38 -> adr 0x38, 0x00, 0x08 ... 0x30; last cti=111.
- Linear write len=3 with ack low 2 cycles on beat 2 -> adr/cti/dat_o held; done_o delayed by 2 cycles.
- Read len=4, wb_err_i on beat 2 -> one rdat_valid_o only, cyc drops next cycle, done_o=err_o=1, req_ready_o=1; repeat with rst pulse mid-burst -> cyc=0 immediately, no done_o.
